reorder_buffer: RTL

In-order reorder buffer directly downstream of dispatch. It accepts up to two new instruction rows per cycle in program order and records out-of-order completions from the three functional units (FU0, FU1, MEM). It retires up to three completed rows per cycle from the head, strictly in order. Retired rows feed back to dispatch as its completion-row input and release old physical destinations to the free list.

---
 rtl/reorder_buffer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer
//   In-order reorder buffer that sits directly after dispatch. Dispatch
//   allocates up to two rows per cycle in program order. The three functional
//   units (FU0, FU1, MEM) mark rows complete out of order. Up to three
//   completed rows retire per cycle from the head, strictly in order.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_alloc_*[0:1]          allocation slots; slot 0 is older than slot 1
//   o_alloc_ready           at least two free entries (from registered count)
//   i_wb_*[0:2]             writeback lanes FU0, FU1, MEM
//   o_retire_*[0:2]         retire lanes; lane 0 is oldest; zero when idle
//   o_free_valid[0:2]       retiring lane releases a non-zero old destination
//   o_count/o_empty/o_full  occupancy
//   o_err                   sticky protocol error
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_alloc_valid     [0:1],
    input  logic [$clog2(DEPTH)-1:0] i_alloc_rob       [0:1],
    input  logic [PREG_W-1:0]        i_alloc_dst       [0:1],
    input  logic [PREG_W-1:0]        i_alloc_old_dst   [0:1],
    input  logic                     i_alloc_regwrite  [0:1],
    input  logic                     i_alloc_memwrite  [0:1],
    output logic                     o_alloc_ready,
    input  logic                     i_wb_valid        [0:2],
    input  logic [$clog2(DEPTH)-1:0] i_wb_rob          [0:2],
    input  logic [DATA_W-1:0]        i_wb_data         [0:2],
    output logic                     o_retire_valid    [0:2],
    output logic [$clog2(DEPTH)-1:0] o_retire_rob      [0:2],
    output logic [PREG_W-1:0]        o_retire_dst      [0:2],
    output logic [PREG_W-1:0]        o_retire_old_dst  [0:2],
    output logic [DATA_W-1:0]        o_retire_data     [0:2],
    output logic                     o_retire_regwrite [0:2],
    output logic                     o_retire_memwrite [0:2],
    output logic                     o_free_valid      [0:2],
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              ent_valid    [DEPTH];
    logic              ent_complete [DEPTH];
    logic [PREG_W-1:0] ent_dst      [DEPTH];
    logic [PREG_W-1:0] ent_old_dst  [DEPTH];
    logic [DATA_W-1:0] ent_data     [DEPTH];
    logic              ent_regwrite [DEPTH];
    logic              ent_memwrite [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic [PTR_W-1:0]  ret_idx   [3];
    logic [2:0]        ret_go;
    logic              prev_go;
    logic [CNT_W-1:0]  n_ret;
    logic [1:0]        acc;
    logic [PTR_W-1:0]  alloc_idx [2];
    logic [CNT_W-1:0]  n_alloc;
    logic [CNT_W-1:0]  count_next;
    logic              alloc_req;
    logic              err_set;

    always_comb begin
        err_set = 1'b0;
        prev_go = 1'b1;
        n_ret   = '0;
        // Retire decisions look only at registered entry state, so a row
        // completed this cycle cannot retire until the next edge.
        for (int unsigned k = 0; k < 3; k++) begin
            ret_idx[k] = head + PTR_W'(k);
            ret_go[k]  = prev_go && ent_valid[ret_idx[k]] && ent_complete[ret_idx[k]];
            prev_go    = ret_go[k];
            n_ret      = n_ret + CNT_W'(ret_go[k]);
        end

        // Acceptance uses the registered ready flag; same-cycle retires do
        // not make room for a same-cycle allocation.
        alloc_req    = i_alloc_valid[0] || i_alloc_valid[1];
        acc[0]       = i_alloc_valid[0] && o_alloc_ready;
        acc[1]       = i_alloc_valid[1] && o_alloc_ready;
        alloc_idx[0] = tail;
        alloc_idx[1] = tail + PTR_W'(acc[0]);
        n_alloc      = CNT_W'(acc[0]) + CNT_W'(acc[1]);
        count_next   = o_count + n_alloc - n_ret;

        if (alloc_req && !o_alloc_ready) begin
            err_set = 1'b1;
        end
        for (int unsigned s = 0; s < 2; s++) begin
            if (acc[s] && (i_alloc_rob[s] != alloc_idx[s])) begin
                err_set = 1'b1;
            end
        end
        for (int unsigned l = 0; l < 3; l++) begin
            if (i_wb_valid[l] && !ent_valid[i_wb_rob[l]]) begin
                err_set = 1'b1;
            end
            for (int unsigned m = l + 1; m < 3; m++) begin
                if (i_wb_valid[l] && i_wb_valid[m] && (i_wb_rob[l] == i_wb_rob[m])) begin
                    err_set = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head          <= '0;
            tail          <= '0;
            o_count       <= '0;
            o_empty       <= 1'b1;
            o_full        <= 1'b0;
            o_alloc_ready <= 1'b1;
            o_err         <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_valid[i]    <= 1'b0;
                ent_complete[i] <= 1'b0;
            end
            for (int unsigned k = 0; k < 3; k++) begin
                o_retire_valid[k]    <= 1'b0;
                o_retire_rob[k]      <= '0;
                o_retire_dst[k]      <= '0;
                o_retire_old_dst[k]  <= '0;
                o_retire_data[k]     <= '0;
                o_retire_regwrite[k] <= 1'b0;
                o_retire_memwrite[k] <= 1'b0;
                o_free_valid[k]      <= 1'b0;
            end
        end else begin
            // Later lanes overwrite earlier ones, so the highest lane wins
            // when two lanes target the same entry.
            for (int unsigned l = 0; l < 3; l++) begin
                if (i_wb_valid[l] && ent_valid[i_wb_rob[l]]) begin
                    ent_complete[i_wb_rob[l]] <= 1'b1;
                    ent_data[i_wb_rob[l]]     <= i_wb_data[l];
                end
            end
            for (int unsigned k = 0; k < 3; k++) begin
                if (ret_go[k]) begin
                    ent_valid[ret_idx[k]]    <= 1'b0;
                    ent_complete[ret_idx[k]] <= 1'b0;
                end
                o_retire_valid[k]    <= ret_go[k];
                o_retire_rob[k]      <= ret_go[k] ? ret_idx[k] : '0;
                o_retire_dst[k]      <= ret_go[k] ? ent_dst[ret_idx[k]] : '0;
                o_retire_old_dst[k]  <= ret_go[k] ? ent_old_dst[ret_idx[k]] : '0;
                o_retire_data[k]     <= ret_go[k] ? ent_data[ret_idx[k]] : '0;
                o_retire_regwrite[k] <= ret_go[k] && ent_regwrite[ret_idx[k]];
                o_retire_memwrite[k] <= ret_go[k] && ent_memwrite[ret_idx[k]];
                o_free_valid[k]      <= ret_go[k] && (ent_old_dst[ret_idx[k]] != '0);
            end
            for (int unsigned s = 0; s < 2; s++) begin
                if (acc[s]) begin
                    ent_valid[alloc_idx[s]]    <= 1'b1;
                    ent_complete[alloc_idx[s]] <= 1'b0;
                    ent_data[alloc_idx[s]]     <= '0;
                    ent_dst[alloc_idx[s]]      <= i_alloc_dst[s];
                    ent_old_dst[alloc_idx[s]]  <= i_alloc_old_dst[s];
                    ent_regwrite[alloc_idx[s]] <= i_alloc_regwrite[s];
                    ent_memwrite[alloc_idx[s]] <= i_alloc_memwrite[s];
                end
            end
            head          <= head + n_ret[PTR_W-1:0];
            tail          <= tail + n_alloc[PTR_W-1:0];
            o_count       <= count_next;
            o_empty       <= (count_next == '0);
            o_full        <= (count_next == CNT_W'(DEPTH));
            o_alloc_ready <= (count_next <= CNT_W'(DEPTH - 2));
            o_err         <= o_err || err_set;
        end
    end

endmodule
